// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths, responder FSM states and
// the latency counter preset helper.
package cpu_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 16;
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter preset for a given latency; out-of-range latencies are clamped.
    function automatic logic [CNT_W-1:0] cnt_preset(input int lat);
        logic [CNT_W-1:0] val;
        if (lat < 1) begin
            val = {CNT_W{1'b0}};
        end else if (lat > MAX_LATENCY) begin
            val = CNT_W'(MAX_LATENCY - 1);
        end else begin
            val = CNT_W'(lat - 1);
        end
        return val;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel between the CPU control path and the memory responder.
interface mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/mem_array.sv
// Word-addressed backing store: synchronous write, combinational read, no reset.
module mem_array #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_r [0:(1<<DEPTH_LOG2)-1];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one load/store at a time and returns the
// response after a fixed programmable latency over a valid/ready channel.
module mem_responder
    import cpu_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = cnt_preset(LATENCY);

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] rdata_s;
    logic              err_r;
    logic              err_s;
    logic              range_err_s;
    logic              wr_req_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] array_rdata_s;

    // Range check uses the full address before it is truncated for indexing.
    generate
        if (ADDR_W > DEPTH_LOG2) begin : g_range
            assign range_err_s = |bus.req_addr[ADDR_W-1:DEPTH_LOG2];
        end else begin : g_norange
            assign range_err_s = 1'b0;
        end
    endgenerate

    // A store seen while reset is held must not reach the array.
    assign wr_en_s = wr_req_s & ~reset;

    mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem_array (
        .clk   (clk),
        .we    (wr_en_s),
        .addr  (bus.req_addr[DEPTH_LOG2-1:0]),
        .wdata (bus.req_wdata),
        .rdata (array_rdata_s)
    );

    // Next-state, counter and response-register update.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        rdata_s  = rdata_r;
        err_s    = err_r;
        wr_req_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    err_s    = range_err_s;
                    wr_req_s = bus.req_we & ~range_err_s;
                    if (bus.req_we || range_err_s) begin
                        rdata_s = {DATA_W{1'b0}};
                    end else begin
                        rdata_s = array_rdata_s;
                    end
                    cnt_s   = CNT_LOAD;
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_s = IDLE;
                    rdata_s = {DATA_W{1'b0}};
                    err_s   = 1'b0;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
                rdata_s = {DATA_W{1'b0}};
                err_s   = 1'b0;
            end
        endcase
    end

    // State and response registers; reset discards any pending response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            rdata_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            rdata_r <= rdata_s;
            err_r   <= err_s;
        end
    end

    // Load data is captured at accept, so it is masked until the response is offered.
    assign bus.req_ready  = (state_r == IDLE);
    assign bus.resp_valid = (state_r == RESP);
    assign bus.busy       = (state_r != IDLE);
    assign bus.resp_rdata = (state_r == RESP) ? rdata_r : {DATA_W{1'b0}};
    assign bus.resp_err   = (state_r == RESP) & err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench: three responders (latency 2, 1, 15) share
// one stimulus; a flat memory model predicts every response.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_ready;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] model_mem [0:255];
    logic [7:0]  wq [$];

    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(16), .ADDR_W(16)) i2 ();
    mem_responder_if #(.DATA_W(16), .ADDR_W(16)) i1 ();
    mem_responder_if #(.DATA_W(16), .ADDR_W(16)) i15 ();

    assign i2.req_valid  = req_valid;
    assign i2.req_we     = req_we;
    assign i2.req_addr   = req_addr;
    assign i2.req_wdata  = req_wdata;
    assign i2.resp_ready = resp_ready;
    assign i1.req_valid  = req_valid;
    assign i1.req_we     = req_we;
    assign i1.req_addr   = req_addr;
    assign i1.req_wdata  = req_wdata;
    assign i1.resp_ready = resp_ready;
    assign i15.req_valid  = req_valid;
    assign i15.req_we     = req_we;
    assign i15.req_addr   = req_addr;
    assign i15.req_wdata  = req_wdata;
    assign i15.resp_ready = resp_ready;

    mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(2))
        u2 (.clk(clk), .reset(reset), .bus(i2.slave));
    mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(1))
        u1 (.clk(clk), .reset(reset), .bus(i1.slave));
    mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(15))
        u15 (.clk(clk), .reset(reset), .bus(i15.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_accept(input logic w, input logic [15:0] a, input logic [15:0] d);
        if (w && a < 16'd256) begin
            model_mem[a[7:0]] = d;
            wq.push_back(a[7:0]);
        end
    endtask

    // One full transaction on the latency-2 responder with an optional stall.
    task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                             input int stall, input string tag);
        logic [15:0] exp_d;
        logic        exp_e;
        int          c;
        exp_e = (a >= 16'd256);
        exp_d = (w || exp_e) ? 16'h0000 : model_mem[a[7:0]];
        req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = d; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        model_accept(w, a, d);
        n_vec++;
        if (i2.busy !== 1'b1 || i2.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s accept: busy=%b req_ready=%b expected 1/0", tag, i2.busy, i2.req_ready);
        end
        c = 0;
        while (i2.resp_valid !== 1'b1 && c < 40) begin
            tick();
            c++;
        end
        n_vec++;
        if (c != 2) begin
            n_err++;
            $display("FAIL %s latency: got %0d edges expected 2", tag, c);
        end
        n_vec++;
        if (i2.resp_rdata !== exp_d || i2.resp_err !== exp_e) begin
            n_err++;
            $display("FAIL %s resp: rdata=%h err=%b expected rdata=%h err=%b",
                     tag, i2.resp_rdata, i2.resp_err, exp_d, exp_e);
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            n_vec++;
            if (i2.resp_valid !== 1'b1 || i2.resp_rdata !== exp_d || i2.resp_err !== exp_e
                || i2.req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s stall%0d: valid=%b rdata=%h err=%b req_ready=%b expected 1/%h/%b/0",
                         tag, s, i2.resp_valid, i2.resp_rdata, i2.resp_err, i2.req_ready, exp_d, exp_e);
            end
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_vec++;
        if (i2.resp_valid !== 1'b0 || i2.resp_rdata !== 16'h0000 || i2.resp_err !== 1'b0
            || i2.req_ready !== 1'b1 || i2.busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s handshake: valid=%b rdata=%h err=%b req_ready=%b busy=%b expected 0/0000/0/1/0",
                     tag, i2.resp_valid, i2.resp_rdata, i2.resp_err, i2.req_ready, i2.busy);
        end
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if (i2.req_ready !== 1'b1 || i2.resp_valid !== 1'b0 || i2.resp_rdata !== 16'h0000
            || i2.resp_err !== 1'b0 || i2.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset: req_ready=%b valid=%b rdata=%h err=%b busy=%b expected 1/0/0000/0/0",
                     i2.req_ready, i2.resp_valid, i2.resp_rdata, i2.resp_err, i2.busy);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        do_access(1'b1, 16'h0010, 16'hBEEF, 0, "store_beef");
        do_access(1'b0, 16'h0010, 16'h0000, 0, "load_beef");
    endtask

    task automatic test_stall();
        logic [15:0] d;
        d = 16'(32'h00000000 | $urandom_range(0, 65535));
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        repeat (2) tick();
        // New store is held pending through the stall and the handshake edge.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0044; req_wdata = d;
        for (int s = 0; s < 5; s++) begin
            n_vec++;
            if (i2.resp_valid !== 1'b1 || i2.resp_rdata !== model_mem[8'h10]
                || i2.resp_err !== 1'b0 || i2.req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall%0d: valid=%b rdata=%h err=%b req_ready=%b expected 1/%h/0/0",
                         s, i2.resp_valid, i2.resp_rdata, i2.resp_err, i2.req_ready, model_mem[8'h10]);
            end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_vec++;
        if (i2.req_ready !== 1'b1 || i2.busy !== 1'b0 || i2.resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: req_ready=%b busy=%b valid=%b expected 1/0/0",
                     i2.req_ready, i2.busy, i2.resp_valid);
        end
        tick();
        req_valid = 1'b0;
        model_accept(1'b1, 16'h0044, d);
        n_vec++;
        if (i2.busy !== 1'b1 || i2.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_next_accept: busy=%b req_ready=%b expected 1/0", i2.busy, i2.req_ready);
        end
        repeat (2) tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        do_access(1'b0, 16'h0044, 16'h0000, 0, "stall_load_back");
    endtask

    task automatic test_out_of_range();
        do_access(1'b1, 16'h0000, 16'hC0DE, 0, "oor_prep");
        do_access(1'b1, 16'h0100, 16'h1234, 2, "oor_store");
        do_access(1'b0, 16'h0000, 16'h0000, 0, "oor_alias_load");
        do_access(1'b0, 16'hFFFF, 16'h0000, 1, "oor_load");
    endtask

    task automatic test_ignored();
        do_access(1'b1, 16'h0020, 16'h1357, 0, "ign_prep");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; resp_ready = 1'b0;
        tick();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'hAAAA;
        tick();
        req_valid = 1'b0;
        tick();
        n_vec++;
        if (i2.resp_valid !== 1'b1 || i2.resp_rdata !== model_mem[8'h10]) begin
            n_err++;
            $display("FAIL ignored_first_resp: valid=%b rdata=%h expected 1/%h",
                     i2.resp_valid, i2.resp_rdata, model_mem[8'h10]);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        do_access(1'b0, 16'h0020, 16'h0000, 0, "ignored_load");
    endtask

    task automatic test_reset_mid_op();
        int seen;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0003; req_wdata = 16'h5A5A; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        model_accept(1'b1, 16'h0003, 16'h5A5A);
        #1;
        reset = 1'b1;
        #1;
        n_vec++;
        if (i2.req_ready !== 1'b1 || i2.busy !== 1'b0 || i2.resp_valid !== 1'b0
            || i2.resp_rdata !== 16'h0000 || i2.resp_err !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: req_ready=%b busy=%b valid=%b rdata=%h err=%b expected 1/0/0/0000/0",
                     i2.req_ready, i2.busy, i2.resp_valid, i2.resp_rdata, i2.resp_err);
        end
        #1;
        reset = 1'b0;
        seen = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (i2.resp_valid === 1'b1 || i2.busy === 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL reset_no_resp: %0d cycles with activity expected 0", seen);
        end
        do_access(1'b0, 16'h0003, 16'h0000, 0, "reset_store_kept");
    endtask

    task automatic test_latency_sweep();
        int lat1, lat15, bad;
        req_valid = 1'b0; resp_ready = 1'b1;
        repeat (25) tick();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
        tick();
        req_valid = 1'b0;
        lat1 = -1; lat15 = -1; bad = 0;
        for (int t = 0; t < 30; t++) begin
            if (lat1 < 0) begin
                if (i1.resp_valid === 1'b1) lat1 = t;
                else if (i1.busy !== 1'b1) bad++;
            end
            if (lat15 < 0) begin
                if (i15.resp_valid === 1'b1) lat15 = t;
                else if (i15.busy !== 1'b1) bad++;
            end
            if (lat1 >= 0 && lat15 >= 0) break;
            tick();
        end
        n_vec++;
        if (lat1 != 1) begin
            n_err++;
            $display("FAIL latency1: got %0d expected 1", lat1);
        end
        n_vec++;
        if (lat15 != 15) begin
            n_err++;
            $display("FAIL latency15: got %0d expected 15", lat15);
        end
        n_vec++;
        if (bad != 0 || i15.resp_rdata !== model_mem[8'h10] || i1.resp_rdata !== model_mem[8'h10]) begin
            n_err++;
            $display("FAIL latency_busy_data: busy_gaps=%0d rdata1=%h rdata15=%h expected 0/%h/%h",
                     bad, i1.resp_rdata, i15.resp_rdata, model_mem[8'h10], model_mem[8'h10]);
        end
        resp_ready = 1'b1;
        repeat (2) tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_random();
        int          kind;
        logic [15:0] a, d;
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 9));
            d = 16'($urandom_range(0, 65535));
            if (kind == 0) begin
                a = 16'(256 + $urandom_range(0, 65279));
                do_access(kind[0] ^ d[0], a, d, int'($urandom_range(0, 3)), "rand_oor");
            end else if (kind < 5 || wq.size() == 0) begin
                a = 16'($urandom_range(0, 255));
                do_access(1'b1, a, d, int'($urandom_range(0, 3)), "rand_store");
            end else begin
                a = {8'h00, wq[$urandom_range(0, wq.size() - 1)]};
                do_access(1'b0, a, d, int'($urandom_range(0, 3)), "rand_load");
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000;
        resp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_stall();
        test_out_of_range();
        test_ignored();
        test_reset_mid_op();
        test_latency_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the processor's unified memory interface: serves one load or store at a time from the CPU control path.
- Uses a valid/ready request channel and a valid/ready response channel, with a programmable fixed latency.
- Owns the word-addressed backing store and flags out-of-range accesses.
- Replaces the zero-latency combinational memory path so that the control unit's ready handshake is actually exercised.

Parameters:
- DATA_W, 16, word width of stored data and of rdata/wdata.
- ADDR_W, 16, width of the request address.
- DEPTH_LOG2, 8, log2 of the number of implemented words (256 at default).
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU presents a request
- req_ready  out  1  responder can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  response available
- resp_ready  in  1  CPU consumes the response
- resp_rdata  out  DATA_W  load data; 0 for stores and errors
- resp_err  out  1  address >= 2**DEPTH_LOG2
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, latency counter=0. Array contents are NOT reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Acceptance occurs at an edge with req_valid=1.
  - On acceptance: capture err = (req_addr[ADDR_W-1:DEPTH_LOG2] != 0).
  - Store with no error: array[req_addr[DEPTH_LOG2-1:0]] <= req_wdata on the accept edge itself.
  - Load with no error: capture array word into the response register on the same edge. Read-before-write ordering is irrelevant because only one request is outstanding.
  - Store or error: response data register <= 0.
  - cnt <= LATENCY-1; state <= WAIT.
- WAIT:
  - req_ready=0.
  - If cnt==0, state <= RESP; otherwise cnt decrements.
  - Net effect: accept at edge k gives resp_valid high after edge k+LATENCY.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are stable and held until the handshake.
  - On an edge with resp_ready=1: state <= IDLE, resp_valid falls.
  - resp_ready=0 stalls indefinitely with no data change.
- req_ready is low in WAIT and RESP. Requests presented there are ignored, not queued. The CPU must hold req_valid until the accept edge.
- Back-to-back throughput: the next accept can occur at edge m+1 at the earliest, where m is the response handshake edge. Peak rate is one access per LATENCY+2 cycles.
- Error access:
  - The write is suppressed.
  - resp_rdata=0 and resp_err=1 for that response only; resp_err is not sticky.
- resp_rdata is 0 whenever resp_valid=0 (cleared on the handshake edge).
- Reset mid-operation:
  - A store already accepted stays committed.
  - A pending load response is discarded.
  - The FSM returns to IDLE immediately; no response is emitted after reset deasserts.
- resp_ready in IDLE/WAIT and req_wdata on loads: ignored.
- Width rules:
  - The address is truncated to DEPTH_LOG2 bits only after the error check.
  - cnt width is 4 bits.
  - No arithmetic is performed on data.

Decomposition:
- Shared package (cpu_pkg):
  - state enum {IDLE, WAIT, RESP}
  - DATA_W/ADDR_W defaults, shared with register_file and the ALU
  - MAX_LATENCY=15
- One natural sub-module, mem_array:
  - 2**DEPTH_LOG2 x DATA_W storage.
  - Synchronous write, combinational read, no reset.
  - Instantiated once; all handshake and FSM logic stays in mem_responder.

Test Plan:
- Store then load, LATENCY=2:
  - Store addr 0x0010 data 0xBEEF: accepted at edge k, resp_valid at k+2, rdata=0, err=0.
  - Load addr 0x0010: rdata=0xBEEF, err=0.
- Response stall:
  - Hold resp_ready=0 for 5 cycles in RESP: resp_valid, rdata and err stay constant and req_ready stays 0.
  - Raise resp_ready: IDLE next edge.
  - A new request is accepted on the edge after that, never earlier.
- Out-of-range, DEPTH_LOG2=8:
  - Store to 0x0100 with 0x1234: resp_err=1, rdata=0.
  - A subsequent load from 0x0000 returns its prior value (no alias write). The next in-range response has err=0.
- Latency sweep LATENCY=1 and 15: resp_valid rises exactly 1 and 15 edges after acceptance; busy=1 throughout.
- Ignored request: pulse req_valid during WAIT with addr 0x0020 write 0xAAAA, then drop it; array[0x20] is unchanged on a later load.
- Async reset in WAIT after a store of 0x5A5A to 0x0003:
  - All outputs go to reset values without a clock edge; no resp_valid follows.
  - A later load of 0x0003 returns 0x5A5A.
